// File: rtl/closest_block_resolver_if.sv
// ============================================================================
// Module      : closest_block_resolver_if
// Description : Per-block intersect input bus and resolved-pixel output bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface closest_block_resolver_if;
    logic        valid_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic [31:0] ray_in_x;
    logic [31:0] ray_in_y;
    logic [31:0] ray_in_z;
    logic        ray_block_intersect_in;
    logic [31:0] best_t_in;
    logic [3:0]  block_index_in;

    logic        valid_out;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic [31:0] ray_out_x;
    logic [31:0] ray_out_y;
    logic [31:0] ray_out_z;
    logic        hit_out;
    logic [31:0] best_t_out;
    logic [3:0]  best_index_out;
    logic        seq_error_out;

    modport master (
        output valid_in, x_in, y_in, ray_in_x, ray_in_y, ray_in_z,
               ray_block_intersect_in, best_t_in, block_index_in,
        input  valid_out, x_out, y_out, ray_out_x, ray_out_y, ray_out_z,
               hit_out, best_t_out, best_index_out, seq_error_out
    );

    modport slave (
        input  valid_in, x_in, y_in, ray_in_x, ray_in_y, ray_in_z,
               ray_block_intersect_in, best_t_in, block_index_in,
        output valid_out, x_out, y_out, ray_out_x, ray_out_y, ray_out_z,
               hit_out, best_t_out, best_index_out, seq_error_out
    );
endinterface

`default_nettype wire

// File: rtl/closest_block_resolver.sv
// ============================================================================
// Module      : closest_block_resolver
// Description : Folds NUM_BLOCKS per-block hits of one pixel into the nearest.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module closest_block_resolver #(
    parameter int NUM_BLOCKS = 12
) (
    input  wire logic              clk_in,
    input  wire logic              rst_in,
    closest_block_resolver_if.slave bus
);

    localparam logic [31:0] c_T_NONE     = 32'h7F80_0000;
    localparam logic [3:0]  c_IDX_NONE   = 4'hF;
    localparam logic [3:0]  c_GROUP_LAST = 4'(NUM_BLOCKS - 1);

    logic [3:0]  r_cnt;
    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic [31:0] r_ray_x, r_ray_y, r_ray_z;
    logic        r_hit;
    logic [31:0] r_best_t;
    logic [3:0]  r_best_idx;

    logic        r_valid_o;
    logic        r_seq_o;
    logic [10:0] r_x_o;
    logic [9:0]  r_y_o;
    logic [31:0] r_ray_x_o, r_ray_y_o, r_ray_z_o;
    logic        r_hit_o;
    logic [31:0] r_best_t_o;
    logic [3:0]  r_best_idx_o;

    logic        w_cand;
    logic        w_mismatch;
    logic        w_start;
    logic        w_base_hit;
    logic [31:0] w_base_t;
    logic [3:0]  w_base_idx;
    logic        w_take;
    logic        w_new_hit;
    logic [31:0] w_new_t;
    logic [3:0]  w_new_idx;
    logic [3:0]  w_cnt_cur;
    logic        w_complete;
    logic [31:0] w_grp_ray_x, w_grp_ray_y, w_grp_ray_z;

    assign w_cand     = bus.ray_block_intersect_in & ~bus.best_t_in[31];
    assign w_mismatch = (r_cnt != 4'd0) && ((bus.x_in != r_x) || (bus.y_in != r_y));
    assign w_start    = (r_cnt == 4'd0) || w_mismatch;

    // A fresh group folds its first entry against an empty "no hit" best.
    assign w_base_hit = w_start ? 1'b0       : r_hit;
    assign w_base_t   = w_start ? c_T_NONE   : r_best_t;
    assign w_base_idx = w_start ? c_IDX_NONE : r_best_idx;

    // Strictly-less keeps the earlier entry on ties; sign bit is excluded.
    assign w_take    = w_cand && (!w_base_hit || (bus.best_t_in[30:0] < w_base_t[30:0]));
    assign w_new_hit = w_take | w_base_hit;
    assign w_new_t   = w_take ? bus.best_t_in      : w_base_t;
    assign w_new_idx = w_take ? bus.block_index_in : w_base_idx;

    assign w_cnt_cur  = w_start ? 4'd0 : r_cnt;
    assign w_complete = (w_cnt_cur == c_GROUP_LAST);

    assign w_grp_ray_x = w_start ? bus.ray_in_x : r_ray_x;
    assign w_grp_ray_y = w_start ? bus.ray_in_y : r_ray_y;
    assign w_grp_ray_z = w_start ? bus.ray_in_z : r_ray_z;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt        <= 4'd0;
            r_x          <= '0;
            r_y          <= '0;
            r_ray_x      <= '0;
            r_ray_y      <= '0;
            r_ray_z      <= '0;
            r_hit        <= 1'b0;
            r_best_t     <= c_T_NONE;
            r_best_idx   <= c_IDX_NONE;
            r_valid_o    <= 1'b0;
            r_seq_o      <= 1'b0;
            r_x_o        <= '0;
            r_y_o        <= '0;
            r_ray_x_o    <= '0;
            r_ray_y_o    <= '0;
            r_ray_z_o    <= '0;
            r_hit_o      <= 1'b0;
            r_best_t_o   <= c_T_NONE;
            r_best_idx_o <= c_IDX_NONE;
        end else begin
            r_valid_o <= 1'b0;
            r_seq_o   <= 1'b0;
            if (bus.valid_in) begin
                if (w_mismatch) begin
                    // Flush the interrupted group as-is; the new entry starts the next one.
                    r_valid_o    <= 1'b1;
                    r_seq_o      <= 1'b1;
                    r_x_o        <= r_x;
                    r_y_o        <= r_y;
                    r_ray_x_o    <= r_ray_x;
                    r_ray_y_o    <= r_ray_y;
                    r_ray_z_o    <= r_ray_z;
                    r_hit_o      <= r_hit;
                    r_best_t_o   <= r_best_t;
                    r_best_idx_o <= r_best_idx;
                end else if (w_complete) begin
                    r_valid_o    <= 1'b1;
                    r_x_o        <= bus.x_in;
                    r_y_o        <= bus.y_in;
                    r_ray_x_o    <= w_grp_ray_x;
                    r_ray_y_o    <= w_grp_ray_y;
                    r_ray_z_o    <= w_grp_ray_z;
                    r_hit_o      <= w_new_hit;
                    r_best_t_o   <= w_new_t;
                    r_best_idx_o <= w_new_idx;
                end
                if (w_start) begin
                    r_x     <= bus.x_in;
                    r_y     <= bus.y_in;
                    r_ray_x <= bus.ray_in_x;
                    r_ray_y <= bus.ray_in_y;
                    r_ray_z <= bus.ray_in_z;
                end
                r_hit      <= w_new_hit;
                r_best_t   <= w_new_t;
                r_best_idx <= w_new_idx;
                r_cnt      <= w_complete ? 4'd0 : (w_cnt_cur + 4'd1);
            end
        end
    end

    assign bus.valid_out      = r_valid_o;
    assign bus.seq_error_out  = r_seq_o;
    assign bus.x_out          = r_x_o;
    assign bus.y_out          = r_y_o;
    assign bus.ray_out_x      = r_ray_x_o;
    assign bus.ray_out_y      = r_ray_y_o;
    assign bus.ray_out_z      = r_ray_z_o;
    assign bus.hit_out        = r_hit_o;
    assign bus.best_t_out     = r_best_t_o;
    assign bus.best_index_out = r_best_idx_o;

endmodule

`default_nettype wire

// File: tb/tb_closest_block_resolver.sv
// ============================================================================
// Module      : tb_closest_block_resolver
// Description : Directed and randomized bench with a group-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_closest_block_resolver;

    localparam int N = 3;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    closest_block_resolver_if bus ();

    closest_block_resolver #(.NUM_BLOCKS(N)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic [31:0] rx, ry, rz;
        logic        hit;
        logic [31:0] t;
        logic [3:0]  idx;
    } entry_t;

    entry_t q[$];

    int checks = 0;
    int errors = 0;
    int dut_pulses = 0;

    logic        m_valid = 1'b0;
    logic        m_seq   = 1'b0;
    logic [10:0] m_x     = '0;
    logic [9:0]  m_y     = '0;
    logic [31:0] m_rx = '0, m_ry = '0, m_rz = '0;
    logic        m_hit   = 1'b0;
    logic [31:0] m_t     = 32'h7F80_0000;
    logic [3:0]  m_idx   = 4'hF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Nearest non-negative hit over the whole group list; first one wins a tie.
    task automatic resolve_group();
        m_x   = q[0].x;  m_y  = q[0].y;
        m_rx  = q[0].rx; m_ry = q[0].ry; m_rz = q[0].rz;
        m_hit = 1'b0; m_t = 32'h7F80_0000; m_idx = 4'hF;
        foreach (q[i]) begin
            if (q[i].hit && !q[i].t[31]) begin
                if (!m_hit || (q[i].t[30:0] < m_t[30:0])) begin
                    m_hit = 1'b1; m_t = q[i].t; m_idx = q[i].idx;
                end
            end
        end
    endtask

    initial begin : model
        entry_t e;
        forever begin
            @(posedge clk_in);
            m_valid = 1'b0;
            m_seq   = 1'b0;
            if (rst_in) begin
                q.delete();
                m_x = '0; m_y = '0; m_rx = '0; m_ry = '0; m_rz = '0;
                m_hit = 1'b0; m_t = 32'h7F80_0000; m_idx = 4'hF;
            end else if (bus.valid_in) begin
                e.x = bus.x_in; e.y = bus.y_in;
                e.rx = bus.ray_in_x; e.ry = bus.ray_in_y; e.rz = bus.ray_in_z;
                e.hit = bus.ray_block_intersect_in; e.t = bus.best_t_in; e.idx = bus.block_index_in;
                if (q.size() > 0 && (q[0].x != e.x || q[0].y != e.y)) begin
                    resolve_group();
                    m_valid = 1'b1;
                    m_seq   = 1'b1;
                    q.delete();
                end
                q.push_back(e);
                if (q.size() == N) begin
                    resolve_group();
                    m_valid = 1'b1;
                    q.delete();
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk_in);
            if (bus.valid_out === 1'b1) dut_pulses++;
            check("valid_out",      {31'd0, bus.valid_out},      {31'd0, m_valid});
            check("seq_error_out",  {31'd0, bus.seq_error_out},  {31'd0, m_seq});
            check("x_out",          {21'd0, bus.x_out},          {21'd0, m_x});
            check("y_out",          {22'd0, bus.y_out},          {22'd0, m_y});
            check("ray_out_x",      bus.ray_out_x,               m_rx);
            check("ray_out_y",      bus.ray_out_y,               m_ry);
            check("ray_out_z",      bus.ray_out_z,               m_rz);
            check("hit_out",        {31'd0, bus.hit_out},        {31'd0, m_hit});
            check("best_t_out",     bus.best_t_out,              m_t);
            check("best_index_out", {28'd0, bus.best_index_out}, {28'd0, m_idx});
        end
    end

    task automatic drive(input logic [10:0] x, input logic [9:0] y, input logic hit,
                         input logic [31:0] t, input logic [3:0] idx);
        bus.valid_in = 1'b1;
        bus.x_in = x; bus.y_in = y;
        bus.ray_in_x = $urandom; bus.ray_in_y = $urandom; bus.ray_in_z = $urandom;
        bus.ray_block_intersect_in = hit; bus.best_t_in = t; bus.block_index_in = idx;
    endtask

    task automatic send(input logic [10:0] x, input logic [9:0] y, input logic hit,
                        input logic [31:0] t, input logic [3:0] idx);
        drive(x, y, hit, t, idx);
        @(posedge clk_in); #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.valid_in = 1'b0;
        repeat (n) begin @(posedge clk_in); #1; end
    endtask

    function automatic logic [31:0] pick_t();
        logic [31:0] tv [6];
        tv[0] = 32'h3F80_0000; tv[1] = 32'h3F00_0000; tv[2] = 32'h4000_0000;
        tv[3] = 32'hBF80_0000; tv[4] = 32'h7F80_0000; tv[5] = $urandom;
        return tv[$urandom_range(0, 5)];
    endfunction

    initial begin : stim
        int p0;
        logic [10:0] px;
        logic [9:0]  py;
        bus.valid_in = 1'b0;
        bus.x_in = '0; bus.y_in = '0;
        bus.ray_in_x = '0; bus.ray_in_y = '0; bus.ray_in_z = '0;
        bus.ray_block_intersect_in = 1'b0; bus.best_t_in = '0; bus.block_index_in = '0;
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;

        check("rst valid_out", {31'd0, bus.valid_out}, 32'd0);
        check("rst hit_out",   {31'd0, bus.hit_out},   32'd0);
        check("rst best_t",    bus.best_t_out,         32'h7F80_0000);
        check("rst best_idx",  {28'd0, bus.best_index_out}, 32'hF);
        check("rst x_out",     {21'd0, bus.x_out},     32'd0);

        // Nearest hit among two, one miss
        send(11'd256, 10'd200, 1'b1, 32'h4000_0000, 4'd0);
        send(11'd256, 10'd200, 1'b1, 32'h3F80_0000, 4'd1);
        send(11'd256, 10'd200, 1'b0, 32'h0000_0000, 4'd2);
        check("g1 valid",   {31'd0, bus.valid_out},      32'd1);
        check("g1 hit",     {31'd0, bus.hit_out},        32'd1);
        check("g1 idx",     {28'd0, bus.best_index_out}, 32'd1);
        check("g1 t",       bus.best_t_out,              32'h3F80_0000);
        check("g1 seq",     {31'd0, bus.seq_error_out},  32'd0);
        check("g1 x",       {21'd0, bus.x_out},          32'd256);
        check("g1 y",       {22'd0, bus.y_out},          32'd200);

        // No candidate at all
        send(11'd0, 10'd0, 1'b0, 32'h3F80_0000, 4'd0);
        send(11'd0, 10'd0, 1'b0, 32'h3F00_0000, 4'd1);
        send(11'd0, 10'd0, 1'b0, 32'h4000_0000, 4'd2);
        check("g2 valid",   {31'd0, bus.valid_out},      32'd1);
        check("g2 hit",     {31'd0, bus.hit_out},        32'd0);
        check("g2 t",       bus.best_t_out,              32'h7F80_0000);
        check("g2 idx",     {28'd0, bus.best_index_out}, 32'hF);

        // Tie keeps earlier; negative t ignored
        send(11'd7, 10'd7, 1'b1, 32'h3F00_0000, 4'd0);
        send(11'd7, 10'd7, 1'b1, 32'hBF80_0000, 4'd1);
        send(11'd7, 10'd7, 1'b1, 32'h3F00_0000, 4'd2);
        check("tie idx",    {28'd0, bus.best_index_out}, 32'd0);
        check("tie t",      bus.best_t_out,              32'h3F00_0000);

        // Pixel change closes the group early
        send(11'd5, 10'd5, 1'b1, 32'h3F80_0000, 4'd0);
        send(11'd5, 10'd5, 1'b0, 32'h3F80_0000, 4'd1);
        send(11'd6, 10'd5, 1'b1, 32'h4000_0000, 4'd0);
        check("seq valid",  {31'd0, bus.valid_out},      32'd1);
        check("seq x",      {21'd0, bus.x_out},          32'd5);
        check("seq flag",   {31'd0, bus.seq_error_out},  32'd1);
        idle(1);
        check("seq drop",   {31'd0, bus.seq_error_out},  32'd0);
        send(11'd6, 10'd5, 1'b0, 32'h3F80_0000, 4'd1);
        send(11'd6, 10'd5, 1'b1, 32'h3F00_0000, 4'd2);
        check("seq2 valid", {31'd0, bus.valid_out},      32'd1);
        check("seq2 x",     {21'd0, bus.x_out},          32'd6);
        check("seq2 flag",  {31'd0, bus.seq_error_out},  32'd0);
        check("seq2 idx",   {28'd0, bus.best_index_out}, 32'd2);

        // Reset aborts a partial group; valid_in ignored during reset
        idle(1);
        p0 = dut_pulses;
        send(11'd9, 10'd9, 1'b1, 32'h3F80_0000, 4'd0);
        send(11'd9, 10'd9, 1'b1, 32'h3F80_0000, 4'd1);
        drive(11'd9, 10'd9, 1'b1, 32'h3F00_0000, 4'd2);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        bus.valid_in = 1'b0;
        send(11'd9, 10'd9, 1'b0, 32'h3F80_0000, 4'd0);
        send(11'd9, 10'd9, 1'b1, 32'h4000_0000, 4'd1);
        send(11'd9, 10'd9, 1'b0, 32'h3F80_0000, 4'd2);
        check("rst grp idx", {28'd0, bus.best_index_out}, 32'd1);
        idle(2);
        check("rst pulses", dut_pulses - p0, 32'd1);

        // Back-to-back groups, gaps inside the second
        p0 = dut_pulses;
        send(11'd1, 10'd2, 1'b1, 32'h4000_0000, 4'd3);
        send(11'd1, 10'd2, 1'b1, 32'h4000_0000, 4'd4);
        send(11'd1, 10'd2, 1'b1, 32'h3F80_0000, 4'd5);
        send(11'd3, 10'd4, 1'b0, 32'h3F80_0000, 4'd6);
        idle(2);
        send(11'd3, 10'd4, 1'b1, 32'h3F00_0000, 4'd7);
        idle(3);
        send(11'd3, 10'd4, 1'b1, 32'h3F00_0000, 4'd8);
        check("b2b idx", {28'd0, bus.best_index_out}, 32'd7);
        idle(2);
        check("b2b pulses", dut_pulses - p0, 32'd2);

        // Randomized traffic
        px = 11'd0; py = 10'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                px = 11'($urandom_range(0, 2));
                py = 10'($urandom_range(0, 1));
            end
            rst_in = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) < 6)
                drive(px, py, 1'($urandom), pick_t(), 4'($urandom));
            else
                bus.valid_in = 1'b0;
            @(posedge clk_in); #1;
        end
        rst_in = 1'b0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/closest_block_resolver.md
CLOSEST_BLOCK_RESOLVER -- requirements
Module: closest_block_resolver

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 12, meaning the number of per-block intersect results per pixel (range 1..15).
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port valid_in, input, 1 bit: one per-block intersect result is present this cycle.
REQ-005 SHALL have port x_in, input, 11 bits: pixel x.
REQ-006 SHALL have port y_in, input, 10 bits: pixel y.
REQ-007 SHALL have ports ray_in_x, ray_in_y and ray_in_z, input, 32 bits each: ray direction as IEEE-754 single.
REQ-008 SHALL have port ray_block_intersect_in, input, 1 bit: the ray hits this block.
REQ-009 SHALL have port best_t_in, input, 32 bits: hit distance as IEEE-754 single.
REQ-010 SHALL have port block_index_in, input, 4 bits: index of the block tested.
REQ-011 SHALL have port valid_out, output, 1 bit: single-cycle pulse marking a resolved pixel.
REQ-012 SHALL have ports x_out (11 bits) and y_out (10 bits), output: the pixel of the resolved group.
REQ-013 SHALL have ports ray_out_x, ray_out_y and ray_out_z, output, 32 bits each: the ray latched from the group's first entry.
REQ-014 SHALL have port hit_out, output, 1 bit: at least one candidate hit occurred in the group.
REQ-015 SHALL have port best_t_out, output, 32 bits: nearest candidate t.
REQ-016 SHALL have port best_index_out, output, 4 bits: block index of the nearest candidate.
REQ-017 SHALL have port seq_error_out, output, 1 bit: the group was closed early by a pixel change.

Function
REQ-018 SHALL keep an entry counter cnt (0..NUM_BLOCKS-1) plus the stored group pixel, ray, best t, best index and hit flag.
REQ-019 SHALL treat an entry as a candidate only when ray_block_intersect_in=1 and best_t_in[31]=0.
REQ-020 SHALL compare candidates as unsigned on best_t bits [30:0]; a strictly smaller value replaces the stored best, and on a tie the earlier entry is kept.
REQ-021 SHALL, on valid_in with cnt=0, latch x, y and the ray, and initialise best from that entry (candidate or not).
REQ-022 SHALL, on valid_in with cnt>0 and (x_in,y_in) equal to the stored pixel, fold the entry into the stored best.
REQ-023 SHALL, on the valid entry that makes the group size NUM_BLOCKS, assert valid_out on the next cycle with a result that includes that entry (latency 1), and return cnt to 0.
REQ-024 SHALL, on valid_in with cnt>0 and a pixel mismatch, emit the partial group next cycle with seq_error_out=1, and start a new group from the incoming entry (cnt=1).
REQ-025 SHALL hold state on cycles with valid_in=0; gaps inside a group are legal and no timeout applies.
REQ-026 SHALL, for a group with no candidate, output hit_out=0, best_t_out=32'h7F800000 and best_index_out=4'hF.
REQ-027 SHALL, for NUM_BLOCKS=1, resolve every valid entry and assert valid_out the following cycle.
REQ-028 SHALL accept back-to-back groups at full rate: a new group's first entry may arrive in the cycle valid_out is high.
REQ-029 SHALL hold all outputs other than valid_out stable until the next valid_out.
REQ-030 SHALL keep valid_out and seq_error_out at 0 except during a result pulse.

Reset
REQ-031 SHALL, while rst_in=1 at a clock edge, clear cnt, valid_out, seq_error_out and hit_out to 0, x_out/y_out and ray outputs to 0, best_t_out to 32'h7F800000 and best_index_out to 4'hF.
REQ-032 SHALL discard a partially accumulated group on reset without emitting it, and SHALL ignore valid_in in the reset cycle.

Verification (NUM_BLOCKS=3 unless stated)
REQ-033 Three entries at pixel (256,200): idx0 hit t=40000000 (2.0), idx1 hit t=3F800000 (1.0), idx2 no hit -> one cycle after idx2, valid_out=1, hit_out=1, best_index_out=1, best_t_out=3F800000, seq_error_out=0.
REQ-034 Three entries at pixel (0,0), all ray_block_intersect_in=0 -> valid_out=1, hit_out=0, best_t_out=7F800000, best_index_out=F.
REQ-035 Tie (idx0 and idx2 both t=3F000000) plus idx1 hit with t=BF800000 (negative) -> best_index_out=0, best_t_out=3F000000.
REQ-036 Two entries at (5,5), then an entry at (6,5) -> pulse with x_out=5, seq_error_out=1; (6,5) continues as a new group, and its completion pulse has seq_error_out=0.
REQ-037 Reset asserted after 2 of 3 entries, then 3 fresh entries -> no pulse for the aborted group, exactly one pulse for the fresh one.
REQ-038 Six entries back-to-back with valid_in gaps inserted in the second group -> exactly two pulses with correct results; outputs unchanged between pulses.
